// File: rtl/dmem_responder_if.sv
// Memory-stage data bus between the pipeline (master) and the data memory
// responder (slave): request fields in cycle N, registered response in N+1.
interface dmem_responder_if;
    logic        memRead_M;
    logic        memWrite_M;
    logic [2:0]  mode_M;
    logic [31:0] addr_M;
    logic [31:0] wdata_M;
    logic [31:0] rdata_W;
    logic        rvalid_W;
    logic        stall_M;
    logic        misalign_fault_W;

    modport master (
        output memRead_M, memWrite_M, mode_M, addr_M, wdata_M,
        input  rdata_W, rvalid_W, stall_M, misalign_fault_W
    );

    modport slave (
        input  memRead_M, memWrite_M, mode_M, addr_M, wdata_M,
        output rdata_W, rvalid_W, stall_M, misalign_fault_W
    );
endinterface

// File: rtl/dmem_responder.sv
// Single-port RV32I data memory with byte/half/word access and latency-1 loads.
// Define DMEM_MISALIGN_SPLIT_EN to split misaligned accesses into two beats; otherwise they fault.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic               clk,
    input  logic               rst,
    dmem_responder_if.slave    bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

`ifdef DMEM_MISALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SPLIT = 1'b1;

    logic [31:0]   mem_q [DEPTH_WORDS];

    logic [0:0]    state_q, state_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          rvalid_q, rvalid_d;
    logic          fault_q, fault_d;

    logic [31:0]   lo_q, lo_d;
    logic [AW-1:0] hi_idx_q, hi_idx_d;
    logic [1:0]    off_q, off_d;
    logic [2:0]    mode_q, mode_d;
    logic [3:0]    be_hi_q, be_hi_d;
    logic [31:0]   wd_hi_q, wd_hi_d;
    logic          sp_rd_q, sp_rd_d;
    logic          sp_wr_q, sp_wr_d;

    logic          req, is_wr, is_rd, misaligned;
    logic [1:0]    off;
    logic [AW-1:0] idx;
    logic [3:0]    size_mask;
    logic [7:0]    be8;
    logic [63:0]   wd64;
    logic [63:0]   win;
    logic [31:0]   rd_lo, rd_hi;

    logic          we;
    logic [AW-1:0] wr_idx;
    logic [3:0]    wr_be;
    logic [31:0]   wr_data;
    logic          stall;

    logic          unused_addr_bits;
    assign unused_addr_bits = ^bus.addr_M[31:AW+2];

    function automatic logic [31:0] load_extend(input logic [31:0] raw, input logic [2:0] mode);
        case (mode)
            3'b000:  load_extend = {{24{raw[7]}}, raw[7:0]};
            3'b001:  load_extend = {{16{raw[15]}}, raw[15:0]};
            3'b100:  load_extend = {24'b0, raw[7:0]};
            3'b101:  load_extend = {16'b0, raw[15:0]};
            default: load_extend = raw;
        endcase
    endfunction

    // Request decode: a simultaneous read and write is a pure store.
    assign req   = bus.memRead_M | bus.memWrite_M;
    assign is_wr = bus.memWrite_M;
    assign is_rd = bus.memRead_M & ~bus.memWrite_M;
    assign off   = bus.addr_M[1:0];
    assign idx   = bus.addr_M[AW+1:2];

    always_comb begin
        case (bus.mode_M[1:0])
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    end

    assign misaligned = ((size_mask == 4'b0011) && (off == 2'b11)) ||
                        ((size_mask == 4'b1111) && (off != 2'b00));

    // Byte lanes over a two-word window; the upper half is only non-zero when misaligned.
    assign be8   = {4'b0, size_mask} << off;
    assign wd64  = {32'b0, bus.wdata_M} << {off, 3'b000};
    assign rd_lo = mem_q[idx];
    assign rd_hi = mem_q[hi_idx_q];
    assign win   = {rd_hi, lo_q} >> {off_q, 3'b000};

    always_comb begin
        state_d  = state_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        fault_d  = 1'b0;
        stall    = 1'b0;
        we       = 1'b0;
        wr_idx   = idx;
        wr_be    = be8[3:0];
        wr_data  = wd64[31:0];
        lo_d     = lo_q;
        hi_idx_d = hi_idx_q;
        off_d    = off_q;
        mode_d   = mode_q;
        be_hi_d  = be_hi_q;
        wd_hi_d  = wd_hi_q;
        sp_rd_d  = sp_rd_q;
        sp_wr_d  = sp_wr_q;
        case (state_q)
            S_SPLIT: begin
                state_d = S_IDLE;
                we      = sp_wr_q;
                wr_idx  = hi_idx_q;
                wr_be   = be_hi_q;
                wr_data = wd_hi_q;
                if (sp_rd_q) begin
                    rvalid_d = 1'b1;
                    rdata_d  = load_extend(win[31:0], mode_q);
                end
            end
            default: begin
                if (req && misaligned && SPLIT_EN) begin
                    // Low beat now; everything the high beat needs is captured here.
                    stall    = 1'b1;
                    state_d  = S_SPLIT;
                    we       = is_wr;
                    lo_d     = rd_lo;
                    hi_idx_d = idx + AW'(1);
                    off_d    = off;
                    mode_d   = bus.mode_M;
                    be_hi_d  = be8[7:4];
                    wd_hi_d  = wd64[63:32];
                    sp_rd_d  = is_rd;
                    sp_wr_d  = is_wr;
                end else if (req && misaligned) begin
                    fault_d = 1'b1;
                    if (is_rd) begin
                        rvalid_d = 1'b1;
                        rdata_d  = 32'b0;
                    end
                end else begin
                    we = is_wr;
                    if (is_rd) begin
                        rvalid_d = 1'b1;
                        rdata_d  = load_extend(rd_lo >> {off, 3'b000}, bus.mode_M);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            rdata_q  <= 32'b0;
            rvalid_q <= 1'b0;
            fault_q  <= 1'b0;
            sp_rd_q  <= 1'b0;
            sp_wr_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            fault_q  <= fault_d;
            sp_rd_q  <= sp_rd_d;
            sp_wr_q  <= sp_wr_d;
        end
    end

    always_ff @(posedge clk) begin
        lo_q     <= lo_d;
        hi_idx_q <= hi_idx_d;
        off_q    <= off_d;
        mode_q   <= mode_d;
        be_hi_q  <= be_hi_d;
        wd_hi_q  <= wd_hi_d;
    end

    // Array is never cleared; a reset cycle suppresses any write, including a pending high beat.
    always_ff @(posedge clk) begin
        if (we && !rst) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    assign bus.rdata_W          = rdata_q;
    assign bus.rvalid_W         = rvalid_q;
    assign bus.misalign_fault_W = fault_q;
    assign bus.stall_M          = stall;
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a byte-level reference memory predicts each
// load/fault response, queued with its due cycle and checked when the cycle arrives.
module tb_dmem_responder;
    localparam int DEPTH = 64;
    localparam int NB    = DEPTH * 4;

`ifdef DMEM_MISALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    typedef struct packed {
        int          due;
        logic        v;
        logic [31:0] d;
        logic        f;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_responder_if bus();

    dmem_responder #(.DEPTH_WORDS(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         cyc = 0;
    int         n_chk = 0;
    int         n_pass = 0;
    bit         mon_en = 1'b0;
    exp_t       sb[$];
    string      tg[$];
    logic [7:0] ref_b [NB];
    logic [2:0] modes [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic int msize(input logic [2:0] md);
        if (md[1:0] == 2'b00) return 1;
        if (md[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit is_mis(input logic [2:0] md, input logic [31:0] a);
        return (msize(md) == 2 && a[1:0] == 2'b11) || (msize(md) == 4 && a[1:0] != 2'b00);
    endfunction

    function automatic void model_store(input logic [31:0] a, input logic [31:0] wd,
                                        input logic [2:0] md, input int lim);
        int base = int'(a % NB);
        for (int i = 0; i < msize(md) && i < lim; i++) ref_b[(base + i) % NB] = wd[8*i +: 8];
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] md);
        logic [31:0] raw = 32'b0;
        int base = int'(a % NB);
        for (int i = 0; i < msize(md); i++) raw[8*i +: 8] = ref_b[(base + i) % NB];
        case (md)
            3'b000:  return {{24{raw[7]}}, raw[7:0]};
            3'b001:  return {{16{raw[15]}}, raw[15:0]};
            3'b100:  return {24'b0, raw[7:0]};
            3'b101:  return {16'b0, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    task automatic set_idle();
        bus.memRead_M  = 1'b0;
        bus.memWrite_M = 1'b0;
        bus.mode_M     = 3'b010;
        bus.addr_M     = 32'b0;
        bus.wdata_M    = 32'b0;
    endtask

    // Called at posedge+1; the request occupies the current cycle (two if split).
    task automatic drive(input string tag, input logic rd, input logic wr, input logic [2:0] md,
                         input logic [31:0] a, input logic [31:0] wd,
                         input bit use_lit, input logic [31:0] lit);
        bit   mis   = is_mis(md, a);
        bit   split = SPLIT_EN && mis && (rd || wr);
        bit   ld    = rd && !wr;
        bit   flt   = mis && !SPLIT_EN && (rd || wr);
        exp_t e;
        if (wr && (!mis || SPLIT_EN)) model_store(a, wd, md, 4);
        if (ld || flt) begin
            e.due = cyc + (split ? 2 : 1);
            e.v   = ld;
            e.f   = flt;
            e.d   = flt ? 32'b0 : (use_lit ? lit : model_load(a, md));
            sb.push_back(e);
            tg.push_back(tag);
        end
        bus.memRead_M  = rd;
        bus.memWrite_M = wr;
        bus.mode_M     = md;
        bus.addr_M     = a;
        bus.wdata_M    = wd;
        #1;
        chk({tag, ".stall"}, 32'(bus.stall_M), 32'(split));
        @(posedge clk); #1;
        if (split) begin
            chk({tag, ".stall2"}, 32'(bus.stall_M), 32'(0));
            @(posedge clk); #1;
        end
        set_idle();
    endtask

    task automatic ld(input string tag, input logic [2:0] md, input logic [31:0] a);
        drive(tag, 1'b1, 1'b0, md, a, 32'b0, 1'b0, 32'b0);
    endtask

    task automatic ldx(input string tag, input logic [2:0] md, input logic [31:0] a, input logic [31:0] lit);
        drive(tag, 1'b1, 1'b0, md, a, 32'b0, 1'b1, lit);
    endtask

    task automatic st(input string tag, input logic [2:0] md, input logic [31:0] a, input logic [31:0] wd);
        drive(tag, 1'b0, 1'b1, md, a, wd, 1'b0, 32'b0);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, ".rdata"},  bus.rdata_W, 32'b0);
        chk({tag, ".rvalid"}, 32'(bus.rvalid_W), 32'(0));
        chk({tag, ".fault"},  32'(bus.misalign_fault_W), 32'(0));
        chk({tag, ".stall"},  32'(bus.stall_M), 32'(0));
    endtask

    always @(negedge clk) begin : monitor
        exp_t  e;
        string t;
        if (mon_en) begin
            if (sb.size() != 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                t = tg.pop_front();
                chk({t, ".rvalid"}, 32'(bus.rvalid_W), 32'(e.v));
                if (e.v) chk({t, ".rdata"}, bus.rdata_W, e.d);
                chk({t, ".fault"}, 32'(bus.misalign_fault_W), 32'(e.f));
            end else begin
                chk("idle.rvalid", 32'(bus.rvalid_W), 32'(0));
                chk("idle.fault", 32'(bus.misalign_fault_W), 32'(0));
            end
            if (sb.size() != 0 && sb[0].due < cyc) begin
                chk({tg[0], ".late"}, 32'(cyc), 32'(sb[0].due));
                void'(sb.pop_front());
                void'(tg.pop_front());
            end
        end
    end

    initial begin
        int          op;
        logic [2:0]  md;
        logic [31:0] a, wd;
        set_idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_zero_outputs("reset");
        mon_en = 1'b1;

        for (int w = 0; w < DEPTH; w++) st("init", 3'b010, 32'(w * 4), $urandom);

        st ("sw_beef", 3'b010, 32'h10, 32'hDEADBEEF);
        ldx("lb_13",   3'b000, 32'h13, 32'hFFFFFFDE);
        ldx("lbu_13",  3'b100, 32'h13, 32'h000000DE);
        ldx("lw_wrap", 3'b010, 32'h1000_0010, 32'hDEADBEEF);

        st ("sw_20",  3'b010, 32'h20, 32'h11223344);
        st ("sh_22",  3'b001, 32'h22, 32'h00008001);
        ldx("lw_20",  3'b010, 32'h20, 32'h80013344);
        ldx("lh_22",  3'b001, 32'h22, 32'hFFFF8001);
        ldx("lhu_22", 3'b101, 32'h22, 32'h00008001);
        ld ("lb_21",  3'b000, 32'h21);

        drive("rdwr_40", 1'b1, 1'b1, 3'b010, 32'h40, 32'h5, 1'b0, 32'b0);
        ldx("lw_40", 3'b010, 32'h40, 32'h00000005);

        st ("sw_m3", 3'b011, 32'h44, 32'hA5A55A5A);
        ld ("lw_m7", 3'b111, 32'h44);

        st ("sw_0", 3'b010, 32'h0, 32'h44332211);
        st ("sw_4", 3'b010, 32'h4, 32'h88776655);
        st ("sw_8", 3'b010, 32'h8, 32'hCAFEF00D);
`ifdef DMEM_MISALIGN_SPLIT_EN
        ldx("lw_1_split", 3'b010, 32'h1, 32'h55443322);
        ld ("lh_3_split", 3'b001, 32'h3);
        ld ("lw_fe_wrap", 3'b010, 32'hFE);
        st ("sw_fd_wrap", 3'b010, 32'hFD, 32'h0BADCAFE);
        ld ("lw_fc_chk",  3'b010, 32'hFC);
        ld ("lw_0_chk",   3'b010, 32'h0);
        st ("sw_0_rest",  3'b010, 32'h0, 32'h44332211);

        // Store whose second beat is cut off by reset.
        model_store(32'h2, 32'hAABBCCDD, 3'b010, 2);
        bus.memWrite_M = 1'b1;
        bus.mode_M     = 3'b010;
        bus.addr_M     = 32'h2;
        bus.wdata_M    = 32'hAABBCCDD;
        #1;
        chk("rst_split.stall", 32'(bus.stall_M), 32'(1));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        set_idle();
        chk_zero_outputs("rst_split");
        ldx("rst_split.w0", 3'b010, 32'h0, 32'hCCDD2211);
        ldx("rst_split.w4", 3'b010, 32'h4, 32'h88776655);
`else
        ld ("lw_1_fault", 3'b010, 32'h1);
        ld ("lhu_3_fault", 3'b101, 32'h3);
        st ("sw_6_fault", 3'b010, 32'h6, 32'hFFFFFFFF);
        ldx("sw_6.w4", 3'b010, 32'h4, 32'h88776655);
        ldx("sw_6.w8", 3'b010, 32'h8, 32'hCAFEF00D);
        drive("rdwr_fault", 1'b1, 1'b1, 3'b001, 32'h7, 32'h1234, 1'b0, 32'b0);
        ld ("lh_2_ok", 3'b001, 32'h2);
`endif

        // Reset with a load result in flight and a store presented during reset.
        ld("pre_rst", 3'b010, 32'h10);
        rst            = 1'b1;
        bus.memWrite_M = 1'b1;
        bus.mode_M     = 3'b010;
        bus.addr_M     = 32'h40;
        bus.wdata_M    = 32'h12345678;
        @(posedge clk); #1;
        rst = 1'b0;
        set_idle();
        chk_zero_outputs("rst_mid");
        ldx("rst_keep", 3'b010, 32'h40, 32'h00000005);

        for (int n = 0; n < 250; n++) begin
            op = $urandom_range(0, 3);
            md = modes[$urandom_range(0, 7)];
            a  = $urandom;
            wd = $urandom;
            case (op)
                0:       begin @(posedge clk); #1; end
                1:       ld("rnd_ld", md, a);
                2:       st("rnd_st", md, a, wd);
                default: drive("rnd_rw", 1'b1, 1'b1, md, a, wd, 1'b0, 32'b0);
            endcase
        end
        for (int w = 0; w < DEPTH; w++) ld("sweep", 3'b010, 32'(w * 4));

        repeat (4) @(posedge clk);
        #1;
        chk("sb.drain", 32'(sb.size()), 32'(0));
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
